// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//
// NCH independent timer channels behind one word-addressed bus slave. Each
// channel has a prescaler, a WIDTH-bit counter with one-shot, auto-reload and
// free-running modes, and a sticky write-1-to-clear pending flag.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   reset    asynchronous active-low reset
//   addr     word address: [CHW+1:2] channel, [1:0] register
//            (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS)
//   we       write strobe, sampled at the rising clk edge
//   datai    write data
//   datao    combinational read data for addr
//   irq_vec  per-channel interrupt (pending & im)
//   irq      OR of irq_vec
// -----------------------------------------------------------------------------
module multi_timer #(
  parameter  int NCH     = 4,
  parameter  int WIDTH   = 32,
  parameter  int PRESC_W = 8,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CHW+1:0]   addr,
  input  logic             we,
  input  logic [31:0]      datai,
  output logic [31:0]      datao,
  output logic [NCH-1:0]   irq_vec,
  output logic             irq
);

  logic [NCH-1:0]              en_q, en_d;
  logic [NCH-1:0]              im_q, im_d;
  logic [NCH-1:0]              pend_q, pend_d;
  logic [NCH-1:0][1:0]         mode_q, mode_d;
  logic [NCH-1:0][PRESC_W-1:0] div_q, div_d;
  logic [NCH-1:0][PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [NCH-1:0][WIDTH-1:0]   preset_q, preset_d;
  logic [NCH-1:0][WIDTH-1:0]   count_q, count_d;

  logic [CHW-1:0]   ch_s;
  logic [1:0]       reg_s;
  logic [WIDTH-1:0] wdata_s;
  logic [NCH-1:0]   hit_s;
  logic [NCH-1:0]   wr_ctrl_s, wr_pre_s, wr_cnt_s, wr_sts_s;
  logic [NCH-1:0]   run_s, tick_s;
  logic [31:0]      rd_s;

  assign ch_s    = addr[CHW+1:2];
  assign reg_s   = addr[1:0];
  assign wdata_s = datai[WIDTH-1:0];

  // Address decode, per-channel write strobes and prescaler tick.
  // A channel index with no matching channel leaves hit_s all zero, so
  // out-of-range accesses neither write nor read anything.
  always_comb begin
    hit_s     = '0;
    wr_ctrl_s = '0;
    wr_pre_s  = '0;
    wr_cnt_s  = '0;
    wr_sts_s  = '0;
    run_s     = '0;
    tick_s    = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_s[i]     = (ch_s == CHW'(i));
      wr_ctrl_s[i] = we & hit_s[i] & (reg_s == 2'd0);
      wr_pre_s[i]  = we & hit_s[i] & (reg_s == 2'd1);
      wr_cnt_s[i]  = we & hit_s[i] & (reg_s == 2'd2);
      wr_sts_s[i]  = we & hit_s[i] & (reg_s == 2'd3);
      run_s[i]     = en_q[i] & (mode_q[i] != 2'd3);
      tick_s[i]    = run_s[i] & (pcnt_q[i] == div_q[i]);
    end
  end

  // Next-state logic: tick effects first (using the old CTRL/PRESET), then
  // bus writes override, so CTRL/COUNT writes beat same-edge tick results.
  always_comb begin
    en_d     = en_q;
    im_d     = im_q;
    mode_d   = mode_q;
    div_d    = div_q;
    preset_d = preset_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    pend_d   = pend_q;
    for (int i = 0; i < NCH; i++) begin
      // W1C first so a same-edge pending set below wins.
      pend_d[i] = pend_q[i] & ~(wr_sts_s[i] & datai[0]);

      // Prescaler: cleared while disabled, frozen in reserved mode 3.
      if (!en_q[i]) begin
        pcnt_d[i] = '0;
      end else if (!run_s[i]) begin
        pcnt_d[i] = pcnt_q[i];
      end else if (tick_s[i]) begin
        pcnt_d[i] = '0;
      end else begin
        pcnt_d[i] = pcnt_q[i] + PRESC_W'(1);
      end

      // A COUNT write on the same edge discards the tick entirely.
      if (tick_s[i] && !wr_cnt_s[i]) begin
        case (mode_q[i])
          2'd0: begin
            if (count_q[i] > WIDTH'(1)) begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end else if (count_q[i] == WIDTH'(1)) begin
              count_d[i] = '0;
              pend_d[i]  = 1'b1;
              en_d[i]    = 1'b0;
            end else begin
              count_d[i] = count_q[i];
            end
          end
          2'd1: begin
            if (count_q[i] > WIDTH'(1)) begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end else begin
              count_d[i] = preset_q[i];
              pend_d[i]  = pend_d[i] | (count_q[i] == WIDTH'(1));
            end
          end
          2'd2: begin
            count_d[i] = count_q[i] + WIDTH'(1);
            pend_d[i]  = pend_d[i] | (&count_q[i]);
          end
          default: begin
            count_d[i] = count_q[i];
          end
        endcase
      end else begin
        count_d[i] = count_q[i];
      end

      if (wr_ctrl_s[i]) begin
        en_d[i]   = datai[0];
        mode_d[i] = datai[2:1];
        im_d[i]   = datai[3];
        div_d[i]  = datai[8 +: PRESC_W];
        pcnt_d[i] = '0;
      end else begin
        div_d[i]  = div_q[i];
      end

      if (wr_pre_s[i]) begin
        preset_d[i] = wdata_s;
      end else begin
        preset_d[i] = preset_q[i];
      end

      if (wr_cnt_s[i]) begin
        count_d[i] = wdata_s;
        pcnt_d[i]  = '0;
      end else begin
        count_d[i] = count_d[i];
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= '0;
      im_q     <= '0;
      mode_q   <= '0;
      div_q    <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pcnt_q   <= '0;
      pend_q   <= '0;
    end else begin
      en_q     <= en_d;
      im_q     <= im_d;
      mode_q   <= mode_d;
      div_q    <= div_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      pend_q   <= pend_d;
    end
  end

  // Read mux; undefined bits and unmatched channels read as zero.
  always_comb begin
    rd_s = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      if (hit_s[i]) begin
        case (reg_s)
          2'd0: begin
            rd_s[0]           = en_q[i];
            rd_s[2:1]         = mode_q[i];
            rd_s[3]           = im_q[i];
            rd_s[8 +: PRESC_W] = div_q[i];
          end
          2'd1:    rd_s[WIDTH-1:0] = preset_q[i];
          2'd2:    rd_s[WIDTH-1:0] = count_q[i];
          2'd3: begin
            rd_s[0] = pend_q[i];
            rd_s[1] = run_s[i];
          end
          default: rd_s = 32'd0;
        endcase
      end else begin
        rd_s = rd_s;
      end
    end
  end

  assign datao   = rd_s;
  assign irq_vec = pend_q & im_q;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_timer
//
// Self-checking bench for multi_timer built with NCH=3, WIDTH=8. A cycle-level
// behavioural model (plain integers per channel) predicts datao/irq_vec/irq on
// every cycle; directed sequences add hard-coded expectations on top.
// -----------------------------------------------------------------------------
module tb_multi_timer;
  localparam int NCH     = 3;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 8;
  localparam int CHW     = 2;
  localparam int AW      = CHW + 2;
  localparam int MAXV    = (1 << WIDTH) - 1;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   addr;
  logic            we;
  logic [31:0]     datai;
  logic [31:0]     datao;
  logic [NCH-1:0]  irq_vec;
  logic            irq;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_en[NCH], m_mode[NCH], m_im[NCH], m_div[NCH];
  int m_pre[NCH], m_cnt[NCH], m_pend[NCH], m_pc[NCH];

  multi_timer #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .datai(datai),
    .datao(datao), .irq_vec(irq_vec), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_div[i] = 0;
      m_pre[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_pc[i] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    int ch;
    int r;
    ch = a >> 2;
    r  = a & 3;
    if (ch >= NCH) return 32'd0;
    case (r)
      0: return 32'(m_en[ch] | (m_mode[ch] << 1) | (m_im[ch] << 3) | (m_div[ch] << 8));
      1: return 32'(m_pre[ch]);
      2: return 32'(m_cnt[ch]);
      default: return 32'(m_pend[ch] | (((m_en[ch] != 0) && (m_mode[ch] != 3)) ? 2 : 0));
    endcase
  endfunction

  function automatic logic [31:0] m_irqv();
    int v;
    v = 0;
    for (int i = 0; i < NCH; i++)
      if (m_pend[i] != 0 && m_im[i] != 0) v = v | (1 << i);
    return 32'(v);
  endfunction

  // One clock edge of the model, applying the timer rules to each channel.
  task automatic m_step(input bit w, input int a, input logic [31:0] d);
    int ch;
    int r;
    bit hit;
    bit tick;
    bit set;
    ch = a >> 2;
    r  = a & 3;
    for (int i = 0; i < NCH; i++) begin
      hit  = w && (ch == i);
      tick = 0;
      set  = 0;
      if (m_en[i] == 0) m_pc[i] = 0;
      else if (m_mode[i] != 3) begin
        if (m_pc[i] == m_div[i]) begin tick = 1; m_pc[i] = 0; end
        else m_pc[i] = m_pc[i] + 1;
      end
      if (tick && !(hit && r == 2)) begin
        if (m_mode[i] == 0) begin
          if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
          else if (m_cnt[i] == 1) begin m_cnt[i] = 0; set = 1; m_en[i] = 0; end
        end else if (m_mode[i] == 1) begin
          if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
          else begin set = (m_cnt[i] == 1); m_cnt[i] = m_pre[i]; end
        end else if (m_mode[i] == 2) begin
          if (m_cnt[i] == MAXV) begin m_cnt[i] = 0; set = 1; end
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (hit) begin
        case (r)
          0: begin
            m_en[i] = int'(d[0]); m_mode[i] = int'(d[2:1]);
            m_im[i] = int'(d[3]); m_div[i] = int'(d[15:8]); m_pc[i] = 0;
          end
          1: m_pre[i] = int'(d[7:0]);
          2: begin m_cnt[i] = int'(d[7:0]); m_pc[i] = 0; end
          default: if (d[0]) m_pend[i] = 0;
        endcase
      end
      if (set) m_pend[i] = 1;
    end
  endtask

  // One bus cycle: drive at the falling edge, check before the rising edge.
  task automatic cyc(input bit w, input int a, input logic [31:0] d,
                     input bit has_exp, input logic [31:0] exp, input string tag);
    we    = w;
    addr  = a[AW-1:0];
    datai = d;
    #1;
    chk("datao", datao, m_read(a));
    chk("irq_vec", {29'd0, irq_vec}, m_irqv());
    chk("irq", {31'd0, irq}, 32'(m_irqv() != 32'd0));
    if (has_exp) chk(tag, datao, exp);
    @(posedge clk);
    m_step(w, a, d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input int a);
    cyc(1'b0, a, 32'd0, 1'b0, 32'd0, "rd");
  endtask

  task automatic rde(input int a, input logic [31:0] exp, input string tag);
    cyc(1'b0, a, 32'd0, 1'b1, exp, tag);
  endtask

  task automatic reset_scan(input string tag);
    for (int a = 0; a < 16; a++) begin
      addr = a[AW-1:0];
      #1;
      chk(tag, datao, 32'd0);
    end
    chk({tag, "_irqv"}, {29'd0, irq_vec}, 32'd0);
    chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  logic [31:0] rdata;
  int          ra;

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    datai = 32'd0;
    m_reset();
    #2;
    reset_scan("rst_init");
    @(negedge clk);
    reset = 1'b1;

    // one-shot on ch0, div=0, im=1
    wr(2, 32'd5);
    wr(0, 32'h9);
    for (int v = 5; v >= 0; v--) rde(2, 32'(v), "oneshot_cnt");
    chk("oneshot_irqv", {29'd0, irq_vec}, 32'd1);
    rde(0, 32'h8, "oneshot_ctrl");
    wr(3, 32'd1);
    chk("oneshot_irq_clr", {31'd0, irq}, 32'd0);
    rde(3, 32'd0, "oneshot_sts");

    // auto-reload on ch1, preset 3, div 2: count steps every 3 cycles
    wr(5, 32'd3);
    wr(6, 32'd3);
    wr(4, 32'h203);
    for (int k = 0; k < 27; k++) rde(6, 32'(3 - ((k / 3) % 3)), "reload_cnt");
    rde(7, 32'd3, "reload_sts");
    wr(7, 32'd1);
    rde(7, 32'd2, "reload_w1c");
    wr(4, 32'd0);

    // free-run on ch2 wraps 0xFF -> 0x00, masked then unmasked
    wr(10, 32'hFE);
    wr(8, 32'h5);
    rde(10, 32'hFE, "free_cnt");
    rde(10, 32'hFF, "free_cnt");
    rde(10, 32'h00, "free_wrap");
    rde(11, 32'd3, "free_sts");
    chk("free_irq_masked", {29'd0, irq_vec}, 32'd0);
    wr(8, 32'hD);
    chk("free_irq_unmasked", {29'd0, irq_vec}, 32'd4);
    wr(8, 32'd0);
    wr(11, 32'd1);
    chk("free_irq_clr", {31'd0, irq}, 32'd0);

    // W1C on the same edge that pending is set
    wr(2, 32'd2);
    wr(0, 32'd1);
    rd(0);
    wr(3, 32'd1);
    rde(3, 32'd1, "w1c_collide");
    wr(3, 32'd1);
    rde(3, 32'd0, "w1c_after");

    // COUNT write on a tick edge wins
    wr(2, 32'd20);
    wr(0, 32'd1);
    rd(2);
    wr(2, 32'd10);
    rde(2, 32'd10, "cnt_collide");
    wr(0, 32'd0);

    // unmapped channel 3: reads zero, writes ignored
    for (int a = 12; a < 16; a++) wr(a, 32'hFFFF_FFFF);
    for (int a = 12; a < 16; a++) rde(a, 32'd0, "unmapped_rd");
    for (int a = 0; a < 12; a++) rd(a);

    // bit masking and reserved mode 3
    wr(0, 32'hFFFF_FFFF);
    rde(0, 32'h0000_FF0F, "ctrl_mask");
    rde(3, 32'd0, "mode3_sts");
    wr(1, 32'hFFFF_FFFF);
    rde(1, 32'h0000_00FF, "preset_mask");
    wr(0, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ra    = int'($urandom_range(0, 15));
      rdata = $urandom;
      if ((ra & 3) == 0 && ($urandom_range(0, 3) != 0)) rdata[15:8] = 8'($urandom_range(0, 3));
      if ((ra & 3) == 2 && ($urandom_range(0, 3) != 0)) rdata = 32'($urandom_range(0, 12));
      cyc($urandom_range(0, 99) < 30, ra, rdata, 1'b0, 32'd0, "rand");
    end

    // reset in the middle of counting on every channel
    for (int c = 0; c < NCH; c++) begin
      wr(c * 4 + 3, 32'd1);
      wr(c * 4 + 2, 32'd200);
      wr(c * 4 + 0, 32'h9);
    end
    rd(2);
    rd(6);
    reset = 1'b0;
    reset_scan("rst_mid");
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) rde(2, 32'd0, "post_rst_idle");
    rde(0, 32'd0, "post_rst_ctrl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
